// File: rtl/conv2_engine.sv
`default_nettype none
// ============================================================================
// Module      : conv2_engine
// Description : Multi-channel 2-D convolution engine. Computes one output pixel
//               per window (one channel per MAC cycle), applies ReLU, an
//               arithmetic right shift and saturation, and emits pixels in
//               raster order over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module conv2_engine #(
  parameter int SIZE      = 7,
  parameter int SIZEKER   = 3,
  parameter int WIDTH_BIT = 8,
  parameter int STRIDE    = 1,
  parameter int CHANNELS  = 1,
  parameter int SHIFT     = 1,
  localparam int OUT      = (SIZE - SIZEKER) / STRIDE + 1,
  localparam int ACCW     = 2 * WIDTH_BIT + $clog2(SIZEKER * SIZEKER * CHANNELS),
  localparam int RW       = $clog2(OUT) + 1
) (
  input  logic                        clock,
  input  logic                        nreset,
  input  logic                        start,
  input  logic signed [WIDTH_BIT-1:0] inpMatrixI [CHANNELS][SIZE][SIZE],
  input  logic signed [WIDTH_BIT-1:0] Kernel     [CHANNELS][SIZEKER][SIZEKER],
  input  logic                        out_ready,
  output logic                        busy,
  output logic                        out_valid,
  output logic signed [WIDTH_BIT-1:0] out_data,
  output logic [RW-1:0]               out_row,
  output logic [RW-1:0]               out_col,
  output logic                        done
);

  localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int IW  = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int KW  = (SIZEKER > 1) ? $clog2(SIZEKER) : 1;

  localparam logic [RW-1:0]  LAST_POS = RW'(OUT - 1);
  localparam logic [CHW-1:0] LAST_CH  = CHW'(CHANNELS - 1);

  localparam logic signed [ACCW-1:0]      MAX_ACC = ACCW'((2 ** (WIDTH_BIT - 1)) - 1);
  localparam logic signed [WIDTH_BIT-1:0] MAX_OUT = {1'b0, {(WIDTH_BIT-1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    EMIT = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t                     state;
  logic [RW-1:0]              row;
  logic [RW-1:0]              col;
  logic [CHW-1:0]             ch;
  logic signed [ACCW-1:0]     acc;
  logic signed [ACCW-1:0]     win_sum;
  logic signed [ACCW-1:0]     acc_next;
  logic signed [WIDTH_BIT-1:0] pix_next;

  // ReLU, then arithmetic shift, then clamp to the largest positive output.
  function automatic logic signed [WIDTH_BIT-1:0] post_process(input logic signed [ACCW-1:0] a);
    logic signed [ACCW-1:0] s;
    s = a >>> SHIFT;
    if (a < 0)
      post_process = '0;
    else if (s > MAX_ACC)
      post_process = MAX_OUT;
    else
      post_process = s[WIDTH_BIT-1:0];
  endfunction

  // Full-precision dot product of the current window with the current channel's kernel.
  always_comb begin
    logic signed [2*WIDTH_BIT-1:0] prod;
    win_sum = '0;
    prod    = '0;
    for (int k = 0; k < SIZEKER; k++) begin
      for (int l = 0; l < SIZEKER; l++) begin
        prod = inpMatrixI[ch][IW'(int'(row) * STRIDE + k)][IW'(int'(col) * STRIDE + l)]
             * Kernel[ch][KW'(k)][KW'(l)];
        win_sum = win_sum + ACCW'(prod);
      end
    end
    acc_next = acc + win_sum;
    pix_next = post_process(acc_next);
  end

  // Control FSM: one channel per MAC cycle, hold pixel in EMIT until accepted.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
      row       <= '0;
      col       <= '0;
      ch        <= '0;
      acc       <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            row   <= '0;
            col   <= '0;
            ch    <= '0;
            acc   <= '0;
            busy  <= 1'b1;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= acc_next;
          if (ch == LAST_CH) begin
            ch        <= '0;
            out_valid <= 1'b1;
            out_data  <= pix_next;
            out_row   <= row;
            out_col   <= col;
            state     <= EMIT;
          end else begin
            ch <= ch + CHW'(1);
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            if (row == LAST_POS && col == LAST_POS) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              if (col == LAST_POS) begin
                col <= '0;
                row <= row + RW'(1);
              end else begin
                col <= col + RW'(1);
              end
              state <= MAC;
            end
          end
        end
        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv2_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv2_engine
// Description : Self-checking bench for conv2_engine. Instance A: 7x7, 3x3,
//               stride 2, 2 channels, shift 1. Instance B: 5x5, 3x3, stride 1,
//               1 channel, shift 0. Pixels are compared with a plain-arithmetic
//               convolution model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv2_engine;

  localparam int W     = 8;
  localparam int SA    = 7;
  localparam int KA    = 3;
  localparam int STA   = 2;
  localparam int CHA   = 2;
  localparam int SHA   = 1;
  localparam int OUTA  = (SA - KA) / STA + 1;
  localparam int SB    = 5;
  localparam int KB    = 3;
  localparam int OUTB  = SB - KB + 1;
  localparam int LIMIT = 400;

  logic clk = 1'b0;
  logic nreset;

  logic                start_a, out_ready_a, busy_a, out_valid_a, done_a;
  logic signed [W-1:0] out_data_a;
  logic [2:0]          out_row_a, out_col_a;
  logic signed [W-1:0] mat_a [CHA][SA][SA];
  logic signed [W-1:0] ker_a [CHA][KA][KA];

  logic                start_b, out_ready_b, busy_b, out_valid_b, done_b;
  logic signed [W-1:0] out_data_b;
  logic [2:0]          out_row_b, out_col_b;
  logic signed [W-1:0] mat_b [1][SB][SB];
  logic signed [W-1:0] ker_b [1][KB][KB];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  conv2_engine #(.SIZE(SA), .SIZEKER(KA), .WIDTH_BIT(W), .STRIDE(STA),
                 .CHANNELS(CHA), .SHIFT(SHA)) u_a (
    .clock(clk), .nreset(nreset), .start(start_a),
    .inpMatrixI(mat_a), .Kernel(ker_a), .out_ready(out_ready_a),
    .busy(busy_a), .out_valid(out_valid_a), .out_data(out_data_a),
    .out_row(out_row_a), .out_col(out_col_a), .done(done_a)
  );

  conv2_engine #(.SIZE(SB), .SIZEKER(KB), .WIDTH_BIT(W), .STRIDE(1),
                 .CHANNELS(1), .SHIFT(0)) u_b (
    .clock(clk), .nreset(nreset), .start(start_b),
    .inpMatrixI(mat_b), .Kernel(ker_b), .out_ready(out_ready_b),
    .busy(busy_b), .out_valid(out_valid_b), .out_data(out_data_b),
    .out_row(out_row_b), .out_col(out_col_b), .done(done_b)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Convolution at output (r,c): sum, ReLU, divide by 2^shift, clamp to 127.
  function automatic int ref_a(int r, int c);
    int s = 0;
    for (int ch = 0; ch < CHA; ch++)
      for (int k = 0; k < KA; k++)
        for (int l = 0; l < KA; l++)
          s += int'(mat_a[ch][r*STA+k][c*STA+l]) * int'(ker_a[ch][k][l]);
    if (s < 0) return 0;
    s = s / (2 ** SHA);
    return (s > 127) ? 127 : s;
  endfunction

  function automatic int ref_b(int r, int c);
    int s = 0;
    for (int k = 0; k < KB; k++)
      for (int l = 0; l < KB; l++)
        s += int'(mat_b[0][r+k][c+l]) * int'(ker_b[0][k][l]);
    if (s < 0) return 0;
    return (s > 127) ? 127 : s;
  endfunction

  task automatic randomize_a();
    for (int ch = 0; ch < CHA; ch++) begin
      for (int i = 0; i < SA; i++)
        for (int j = 0; j < SA; j++) mat_a[ch][i][j] = W'($urandom);
      for (int k = 0; k < KA; k++)
        for (int l = 0; l < KA; l++) ker_a[ch][k][l] = W'($urandom);
    end
  endtask

  // mode 0: always ready; 1: random ready and stray start pulses; 2: 5-cycle stall on pixel 4.
  task automatic frame_a(input int mode);
    int got = 0, dones = 0, first_v = -1, done_at = -1, stall = 0;
    logic pv = 1'b0, rdy;
    start_a = 1'b1;
    @(negedge clk);
    if (mode != 1) start_a = 1'b0;
    chk("a_busy_after_start", busy_a, 1);
    for (int n = 1; n < LIMIT && dones == 0; n++) begin
      if (pv) chk("a_hold_valid", out_valid_a, 1);
      if (out_valid_a) begin
        if (first_v < 0) first_v = n;
        chk("a_row", out_row_a, got / OUTA);
        chk("a_col", out_col_a, got % OUTA);
        chk("a_data", out_data_a, ref_a(got / OUTA, got % OUTA));
      end
      if (done_a) begin
        dones++;
        done_at = n;
        start_a = 1'b0;
        chk("a_pixels_at_done", got, OUTA * OUTA);
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ($urandom_range(0, 3) != 0);
        default: rdy = !(got == 4 && stall < 5);
      endcase
      if (out_valid_a && !rdy) stall++;
      out_ready_a = rdy;
      if (mode == 1) start_a = (dones == 0) ? 1'($urandom) : 1'b0;
      pv = out_valid_a && !rdy;
      if (out_valid_a && rdy) got++;
      @(negedge clk);
    end
    start_a = 1'b0;
    chk("a_pixel_count", got, OUTA * OUTA);
    chk("a_done_pulses", dones, 1);
    chk("a_done_one_cycle", done_a, 0);
    chk("a_idle_busy", busy_a, 0);
    chk("a_idle_valid", out_valid_a, 0);
    if (mode == 0) begin
      chk("a_first_valid_cycle", first_v, CHA + 1);
      chk("a_done_cycle", done_at, OUTA * OUTA * (CHA + 1) + 1);
    end
    if (mode == 2) chk("a_stall_cycles", stall, 5);
  endtask

  task automatic frame_b();
    int got = 0, dones = 0, first_v = -1, done_at = -1;
    out_ready_b = 1'b1;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int n = 1; n < LIMIT && dones == 0; n++) begin
      if (out_valid_b) begin
        if (first_v < 0) first_v = n;
        chk("b_row", out_row_b, got / OUTB);
        chk("b_col", out_col_b, got % OUTB);
        chk("b_data", out_data_b, ref_b(got / OUTB, got % OUTB));
        got++;
      end
      if (done_b) begin
        dones++;
        done_at = n;
      end
      @(negedge clk);
    end
    chk("b_pixel_count", got, OUTB * OUTB);
    chk("b_first_valid_cycle", first_v, 2);
    chk("b_done_cycle", done_at, 19);
    chk("b_done_one_cycle", done_b, 0);
    chk("b_idle_busy", busy_b, 0);
  endtask

  initial begin
    nreset = 1'b0;
    start_a = 1'b0; out_ready_a = 1'b0;
    start_b = 1'b0; out_ready_b = 1'b0;
    for (int ch = 0; ch < CHA; ch++) begin
      for (int i = 0; i < SA; i++) for (int j = 0; j < SA; j++) mat_a[ch][i][j] = '0;
      for (int k = 0; k < KA; k++) for (int l = 0; l < KA; l++) ker_a[ch][k][l] = '0;
    end
    for (int i = 0; i < SB; i++) for (int j = 0; j < SB; j++) mat_b[0][i][j] = 8'sd1;
    for (int k = 0; k < KB; k++) for (int l = 0; l < KB; l++) ker_b[0][k][l] = 8'sd1;

    repeat (3) @(negedge clk);
    chk("rst_busy", busy_a, 0);
    chk("rst_valid", out_valid_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_data", out_data_a, 0);
    chk("rst_row", out_row_a, 0);
    chk("rst_col", out_col_a, 0);
    chk("rst_b_busy", busy_b, 0);
    chk("rst_b_valid", out_valid_b, 0);
    nreset = 1'b1;
    @(negedge clk);

    // All ones: every pixel is 9.
    frame_b();
    // Negative weights: ReLU forces every pixel to 0.
    for (int k = 0; k < KB; k++) for (int l = 0; l < KB; l++) ker_b[0][k][l] = -8'sd1;
    frame_b();

    // Random data, ready tied high.
    randomize_a();
    frame_a(0);
    // Random data, random backpressure, start toggling while busy.
    randomize_a();
    frame_a(1);
    // Channel 1 is channel 0 with negated weights: all outputs 0.
    randomize_a();
    for (int i = 0; i < SA; i++) for (int j = 0; j < SA; j++) mat_a[1][i][j] = mat_a[0][i][j];
    for (int k = 0; k < KA; k++) for (int l = 0; l < KA; l++) ker_a[1][k][l] = -ker_a[0][k][l];
    frame_a(0);
    // Saturation: everything 127, with a 5-cycle stall mid-frame.
    for (int ch = 0; ch < CHA; ch++) begin
      for (int i = 0; i < SA; i++) for (int j = 0; j < SA; j++) mat_a[ch][i][j] = 8'sd127;
      for (int k = 0; k < KA; k++) for (int l = 0; l < KA; l++) ker_a[ch][k][l] = 8'sd127;
    end
    frame_a(2);
    // Stride marker: only input rows 2..4, cols 4..6 of channel 0 are nonzero.
    for (int ch = 0; ch < CHA; ch++) begin
      for (int i = 0; i < SA; i++) for (int j = 0; j < SA; j++) mat_a[ch][i][j] = '0;
      for (int k = 0; k < KA; k++)
        for (int l = 0; l < KA; l++) ker_a[ch][k][l] = (ch == 0) ? 8'sd1 : 8'sd0;
    end
    for (int i = 2; i <= 4; i++)
      for (int j = 4; j <= 6; j++) mat_a[0][i][j] = W'(i * 3 + j);
    frame_a(0);

    // Mid-frame reset abort, then a full frame.
    randomize_a();
    out_ready_a = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (9) @(negedge clk);
    nreset = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    chk("abort_busy", busy_a, 0);
    chk("abort_valid", out_valid_a, 0);
    chk("abort_done", done_a, 0);
    chk("abort_data", out_data_a, 0);
    chk("abort_row", out_row_a, 0);
    chk("abort_col", out_col_a, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", done_a, 0);
      chk("abort_stays_idle", busy_a, 0);
    end
    frame_a(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
